online_mult_seq_ctrl: RTL and testbench

Sequencer for the radix-2 online multiplier iteration datapath (the V_j / selection stage).
- Accepts MSB-first signed-digit operand pairs over a valid/ready handshake.
- Builds the X_j/Y_j operand prefixes and the W_j residual register, and drives the current digits into the datapath.
- Suppresses the first delta selection results and streams exactly no_of_digits product digits out over valid/ready with backpressure.

---
 rtl/online_mult_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_online_mult_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/online_mult_seq_ctrl.sv
// Control sequencer for the radix-2 online multiplier V_j/selection stage; optional DIGIT_CHECK_EN adds the err port.
// An output digit is registered on each iteration from j=delta onward. A held output (out_valid & ~out_ready) freezes all iterations.
module online_mult_seq_ctrl #(
    parameter int no_of_digits = 4,
    parameter int radix_bits   = 2,
    parameter int radix        = 2,
    parameter int delta        = 3
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [radix_bits-1:0]                         x_in,
    input  logic [radix_bits-1:0]                         y_in,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [radix_bits-1:0]                         p_out,
    output logic                                          out_last,
    output logic [no_of_digits*radix_bits-1:0]            X_j,
    output logic [no_of_digits*radix_bits-1:0]            Y_j,
    output logic [radix_bits-1:0]                         x_j_1,
    output logic [radix_bits-1:0]                         y_j_1,
    output logic [radix_bits*(no_of_digits+delta+1)-1:0]  W_j,
    input  logic [radix_bits*(no_of_digits+delta+1)-1:0]  V_j,
    input  logic [radix_bits-1:0]                         p_j
`ifdef DIGIT_CHECK_EN
    ,
    output logic                                          err
`endif
);

    localparam int N     = no_of_digits;
    localparam int RB    = radix_bits;
    localparam int WW    = RB * (N + delta + 1);
    localparam int JW    = $clog2(N + delta + 1);
    localparam int J_END = N + delta;

    if (radix != 2 || delta >= no_of_digits) begin : g_bad_params
        $error("online_mult_seq_ctrl: needs radix 2 and delta < no_of_digits");
    end

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [JW-1:0]   j_q, j_d, j_next;
    logic [N*RB-1:0] X_j_q, X_j_d, Y_j_q, Y_j_d;
    logic [WW-1:0]   W_j_q, W_j_d;
    logic [RB-1:0]   p_out_q, p_out_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            stall, accepting, fire, bad_dig;
    logic [RB-1:0]   x_dig, y_dig;

`ifdef DIGIT_CHECK_EN
    localparam logic [RB-1:0] DIG_NEG2 = RB'(1) << (RB - 1);
`endif

    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        X_j_d       = X_j_q;
        Y_j_d       = Y_j_q;
        W_j_d       = W_j_q;
        p_out_d     = p_out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        err_d       = err_q;
        j_next      = j_q + 1'b1;

        stall     = out_valid_q & ~out_ready;
        accepting = (state_q == S_PRIME) || (state_q == S_STREAM);
        in_ready  = accepting & ~stall;
        busy      = (state_q != S_IDLE);

`ifdef DIGIT_CHECK_EN
        // An illegal -2 digit is still consumed, but enters the datapath as zero.
        bad_dig = (x_in == DIG_NEG2) || (y_in == DIG_NEG2);
        x_dig   = (x_in == DIG_NEG2) ? '0 : x_in;
        y_dig   = (y_in == DIG_NEG2) ? '0 : y_in;
`else
        bad_dig = 1'b0;
        x_dig   = x_in;
        y_dig   = y_in;
`endif
        x_j_1 = accepting ? x_dig : '0;
        y_j_1 = accepting ? y_dig : '0;

        fire = accepting ? (in_valid & in_ready)
                         : ((state_q == S_DRAIN) && !stall && (j_q < JW'(J_END)));

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        if (state_q == S_IDLE && start) begin
            X_j_d   = '0;
            Y_j_d   = '0;
            W_j_d   = '0;
            j_d     = '0;
            err_d   = 1'b0;
            state_d = (delta == 0) ? S_STREAM : S_PRIME;
        end

        if (fire) begin
            for (int k = 0; k < N; k++) begin
                if (j_q == JW'(N - 1 - k)) begin
                    X_j_d[k*RB +: RB] = x_dig;
                    Y_j_d[k*RB +: RB] = y_dig;
                end
            end
            if (accepting && bad_dig) err_d = 1'b1;
            // Residual keeps V_j but removes the selected digit from its top field.
            W_j_d              = V_j;
            W_j_d[WW-1 -: RB]  = V_j[WW-1 -: RB] - p_j;
            if (j_q >= JW'(delta)) begin
                p_out_d     = p_j;
                out_valid_d = 1'b1;
                out_last_d  = (j_q == JW'(J_END - 1));
            end
            j_d = j_next;
            if (state_q == S_PRIME && j_next == JW'(delta)) state_d = S_STREAM;
            if (state_q == S_STREAM && j_next == JW'(N))    state_d = S_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            j_q         <= '0;
            X_j_q       <= '0;
            Y_j_q       <= '0;
            W_j_q       <= '0;
            p_out_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            X_j_q       <= X_j_d;
            Y_j_q       <= Y_j_d;
            W_j_q       <= W_j_d;
            p_out_q     <= p_out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign X_j       = X_j_q;
    assign Y_j       = Y_j_q;
    assign W_j       = W_j_q;
    assign p_out     = p_out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
`ifdef DIGIT_CHECK_EN
    assign err       = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_online_mult_seq_ctrl.sv
// Bench for online_mult_seq_ctrl with N=4, delta=3: operand table, scoreboarded product digits, and hand sequences.
module tb_online_mult_seq_ctrl;
    localparam int N  = 4;
    localparam int D  = 3;
    localparam int RB = 2;
    localparam int WW = RB * (N + D + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, busy, done, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [RB-1:0] x_in, y_in, p_out, x_j_1, y_j_1, p_j;
    logic [N*RB-1:0] X_j, Y_j;
    logic [WW-1:0] W_j, V_j;
`ifdef DIGIT_CHECK_EN
    logic err;
`endif

    online_mult_seq_ctrl #(.no_of_digits(N), .radix_bits(RB), .radix(2), .delta(D)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out), .out_last(out_last),
        .X_j(X_j), .Y_j(Y_j), .x_j_1(x_j_1), .y_j_1(y_j_1), .W_j(W_j), .V_j(V_j), .p_j(p_j)
`ifdef DIGIT_CHECK_EN
        , .err(err)
`endif
    );

    typedef struct packed {
        logic [3:0][1:0] x;   // x[0] is the first (most significant) digit
        logic [3:0][1:0] y;
        logic [7:0]      ex;
        logic [7:0]      ey;
    } vec_t;
    vec_t tbl[4];

    typedef struct packed { logic [1:0] p; logic last; } sb_t;
    sb_t q[$];

    int n_chk = 0;
    int n_pass = 0;

    logic          act_m, ov_m, done_m, err_m, acc_fire;
    int            it_m, n_out;
    logic [7:0]    X_m, Y_m;
    logic [WW-1:0] W_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [1:0] san(input logic [1:0] d);
`ifdef DIGIT_CHECK_EN
        return (d == 2'b10) ? 2'b00 : d;
`else
        return d;
`endif
    endfunction

    function automatic logic [WW-1:0] rnd_v();
        return WW'($urandom);
    endfunction

    function automatic logic [1:0] rnd_p();
        case ($urandom_range(0, 2))
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    task automatic model_clear();
        act_m = 0; ov_m = 0; done_m = 0; err_m = 0; it_m = 0;
        X_m = '0; Y_m = '0; W_m = '0; q.delete();
    endtask

    // One clock: drive inputs just after a falling edge, check combinational outputs,
    // advance the model, then check registered outputs at the next falling edge.
    task automatic step(input logic iv, input logic [1:0] xi, input logic [1:0] yi,
                        input logic ordy, input logic st, input logic [WW-1:0] v, input logic [1:0] pj);
        logic stall, exp_ir, fire, hs, last_hs;
        logic [1:0] xs, ys;
        sb_t e;
        in_valid = iv; x_in = xi; y_in = yi; out_ready = ordy; start = st; V_j = v; p_j = pj;
        #1;
        stall  = ov_m & ~ordy;
        exp_ir = act_m && (it_m < N) && !stall;
        chk("in_ready", in_ready, exp_ir);
        xs = (act_m && it_m < N) ? san(xi) : 2'b00;
        ys = (act_m && it_m < N) ? san(yi) : 2'b00;
        chk("x_j_1", x_j_1, xs);
        chk("y_j_1", y_j_1, ys);
        fire     = act_m && ((it_m < N) ? (iv && exp_ir) : ((it_m < N + D) && !stall));
        acc_fire = fire && (it_m < N);
        hs       = ov_m && ordy;
        last_hs  = 0;
        if (hs) begin
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = q.pop_front();
                chk("p_out", p_out, e.p);
                chk("out_last", out_last, e.last);
                last_hs = e.last;
                n_out++;
            end
        end
        done_m = last_hs;
        if (!act_m) begin
            if (st) begin
                act_m = 1; it_m = 0; X_m = '0; Y_m = '0; W_m = '0; err_m = 0;
            end
        end else begin
            if (hs) ov_m = 0;
            if (fire) begin
                if (it_m < N) begin
                    X_m[(N-1-it_m)*RB +: RB] = san(xi);
                    Y_m[(N-1-it_m)*RB +: RB] = san(yi);
                    if (xi != san(xi) || yi != san(yi)) err_m = 1;
                end
                W_m = v;
                W_m[WW-1 -: RB] = v[WW-1 -: RB] - pj;
                if (it_m >= D) begin
                    e.p = pj; e.last = (it_m == N + D - 1);
                    q.push_back(e);
                    ov_m = 1;
                end
                it_m++;
            end
            if (last_hs) act_m = 0;
        end
        @(negedge clk);
        chk("out_valid", out_valid, ov_m);
        chk("busy", busy, act_m);
        chk("done", done, done_m);
        chk("X_j", X_j, X_m);
        chk("Y_j", Y_j, Y_m);
        chk("W_j", W_j, W_m);
`ifdef DIGIT_CHECK_EN
        chk("err", err, err_m);
`endif
    endtask

    task automatic do_reset();
        reset = 0; start = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0); chk("rst_out_valid", out_valid, 0);
        chk("rst_p_out", p_out, 0);    chk("rst_out_last", out_last, 0);
        chk("rst_X_j", X_j, 0);        chk("rst_Y_j", Y_j, 0);
        chk("rst_W_j", W_j, 0);        chk("rst_x_j_1", x_j_1, 0);
`ifdef DIGIT_CHECK_EN
        chk("rst_err", err, 0);
`endif
        reset = 1;
        model_clear();
    endtask

    // mode 0: full rate, 1: random input gaps and output backpressure, 2: 3-cycle stall on first output
    task automatic run_op(input int idx, input int mode, input logic st_busy);
        int k, cyc, bp;
        logic iv, ordy;
        logic [1:0] xd, yd, ki;
        n_out = 0; k = 0; bp = 0; cyc = 0;
        step(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, rnd_v(), rnd_p());
        while (act_m && cyc < 60) begin
            ki   = k[1:0];
            iv   = (k < N) && (mode != 1 || $urandom_range(0, 3) != 0);
            xd   = (k < N) ? tbl[idx].x[ki] : 2'b00;
            yd   = (k < N) ? tbl[idx].y[ki] : 2'b00;
            ordy = 1'b1;
            if (mode == 1) ordy = 1'($urandom_range(0, 1));
            if (mode == 2 && ov_m && bp < 3) begin
                ordy = 1'b0;
                bp++;
                chk("bp_p_out_held", p_out, q[0].p);
                chk("bp_out_valid_held", out_valid, 1);
            end
            step(iv, xd, yd, ordy, st_busy, rnd_v(), rnd_p());
            if (acc_fire) k++;
            cyc++;
        end
        if (act_m) chk("op_timeout", 0, 1);
        chk("op_digit_count", n_out, N);
        chk("op_sb_empty", q.size(), 0);
        chk("tbl_X_j", X_j, tbl[idx].ex);
        chk("tbl_Y_j", Y_j, tbl[idx].ey);
        chk("op_idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].x = {2'b00, 2'b00, 2'b00, 2'b00}; tbl[0].y = {2'b00, 2'b00, 2'b00, 2'b00};
        tbl[0].ex = 8'h00; tbl[0].ey = 8'h00;
        tbl[1].x = {2'b01, 2'b11, 2'b00, 2'b01}; tbl[1].y = {2'b00, 2'b00, 2'b01, 2'b11};
        tbl[1].ex = 8'b01_00_11_01; tbl[1].ey = 8'b11_01_00_00;
        tbl[2].x = {2'b11, 2'b11, 2'b11, 2'b11}; tbl[2].y = {2'b01, 2'b01, 2'b01, 2'b01};
        tbl[2].ex = 8'hFF; tbl[2].ey = 8'h55;
        tbl[3].x = {2'b11, 2'b00, 2'b01, 2'b00}; tbl[3].y = {2'b00, 2'b01, 2'b11, 2'b01};
        tbl[3].ex = 8'h13; tbl[3].ey = 8'h74;

        reset = 0; start = 0; in_valid = 0; out_ready = 0;
        x_in = '0; y_in = '0; V_j = '0; p_j = '0;
        model_clear();
        n_out = 0;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            run_op(i, (i == 2) ? 1 : ((i == 3) ? 2 : 0), i == 3);
        end

        // residual update, then reset in STREAM (j==3)
        step(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, rnd_v(), rnd_p());
        step(1'b1, 2'b01, 2'b11, 1'b1, 1'b0, 16'h6A3C, 2'b01);
        chk("W_top_minus_p", W_j, 16'h2A3C);
        step(1'b1, 2'b00, 2'b01, 1'b1, 1'b0, rnd_v(), rnd_p());
        step(1'b1, 2'b11, 2'b00, 1'b1, 1'b0, rnd_v(), rnd_p());
        chk("pre_reset_busy", busy, 1);
        in_valid = 1; out_ready = 1;
        do_reset();
        run_op(1, 0, 1'b0);
        run_op(3, 1, 1'b1);

`ifdef DIGIT_CHECK_EN
        tbl[0].x = {2'b00, 2'b00, 2'b10, 2'b01};
        tbl[0].ex = 8'h40;
        run_op(0, 0, 1'b0);
        chk("err_sticky", err, 1);
        run_op(1, 0, 1'b0);
        chk("err_cleared_on_start", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
